eth_tx_arb: RTL and testbench

Packet-granular, two-input round-robin arbiter that shares the single 10G MAC transmit AXI-Stream port between two requesters, e.g. the KV encapsulation reply path and a management/ARP responder. It sits between the requesters and the MAC `s_axis_tx_*` port in the `clk156` domain. Once a port is granted, it holds the grant for that port's whole frame. It also keeps per-port frame counters and oversize-frame flags for debug.

---
 rtl/eth_pkg.sv | 7 +
 rtl/eth_tx_arb.sv | 95 +++++++++
 tb/tb_eth_tx_arb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared AXIS widths, arbiter state type and oversize threshold default.
package eth_pkg;
  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int DEF_MAX_BEATS = 1024;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_e;
endpackage

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: packet-granular 2-way round-robin arbiter onto the MAC TX AXI-Stream port.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tuser,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [1:0]            grant,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1,
  output logic [1:0]            oversize
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  arb_state_e state_q, state_d;
  logic last_srv_q, last_srv_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0] pkt_cnt0_q, pkt_cnt0_d, pkt_cnt1_q, pkt_cnt1_d;
  logic [1:0] oversize_q, oversize_d;
  logic sel1, busy, acc;
  always_comb begin
    sel1 = state_q == GNT1;
    busy = state_q != IDLE;
    m_axis_tvalid = busy && (sel1 ? s1_axis_tvalid : s0_axis_tvalid);
    m_axis_tdata = !busy ? '0 : sel1 ? s1_axis_tdata : s0_axis_tdata;
    m_axis_tkeep = !busy ? '0 : sel1 ? s1_axis_tkeep : s0_axis_tkeep;
    m_axis_tlast = busy && (sel1 ? s1_axis_tlast : s0_axis_tlast);
    m_axis_tuser = busy && (sel1 ? s1_axis_tuser : s0_axis_tuser);
    s0_axis_tready = state_q == GNT0 && m_axis_tready;
    s1_axis_tready = sel1 && m_axis_tready;
    acc = m_axis_tvalid && m_axis_tready;
    state_d = state_q;
    last_srv_d = last_srv_q;
    beat_d = beat_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    oversize_d = oversize_q;
    if (!busy) begin
      beat_d = '0;
      // On a tie, the port not served last wins.
      if (s0_axis_tvalid && (!s1_axis_tvalid || last_srv_q)) state_d = GNT0;
      else if (s1_axis_tvalid) state_d = GNT1;
    end else if (acc) begin
      if (beat_q != BW'(MAX_BEATS)) beat_d = beat_q + 1'b1;
      if (beat_d == BW'(MAX_BEATS)) oversize_d[sel1] = 1'b1;
      if (m_axis_tlast) begin
        state_d = IDLE;
        last_srv_d = sel1;
        pkt_cnt0_d = pkt_cnt0_q + {31'd0, !sel1};
        pkt_cnt1_d = pkt_cnt1_q + {31'd0, sel1};
      end
    end
  end
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      state_q <= IDLE;
      last_srv_q <= 1'b1;
      beat_q <= '0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
      oversize_q <= '0;
    end else begin
      state_q <= state_d;
      last_srv_q <= last_srv_d;
      beat_q <= beat_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
      oversize_q <= oversize_d;
    end
  end
  assign grant = {state_q == GNT1, state_q == GNT0};
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign oversize = oversize_q;
endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed frames against an owner/queue model of the arbiter, checked every cycle.
module tb_eth_tx_arb;
  localparam int MB = 8;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic u;} beat_t;
  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;
  logic eth_rst_n;
  logic s0_axis_tvalid, s0_axis_tready, s0_axis_tlast, s0_axis_tuser;
  logic [63:0] s0_axis_tdata;
  logic [7:0] s0_axis_tkeep;
  logic s1_axis_tvalid, s1_axis_tready, s1_axis_tlast, s1_axis_tuser;
  logic [63:0] s1_axis_tdata;
  logic [7:0] s1_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0] m_axis_tkeep;
  logic [1:0] grant, oversize;
  logic [31:0] pkt_cnt0, pkt_cnt1;

  eth_tx_arb #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .MAX_BEATS(MB)) dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .oversize(oversize)
  );

  beat_t q0[$], q1[$];
  logic [63:0] obs[$];
  int glog[$];
  int vec = 0, mis = 0, cyc = 0, t_req = 0, t_first = -1;
  int own = -1, last = 1, beat = 0, pk0 = 0, pk1 = 0;
  logic [1:0] ov = 2'b00;
  logic gap0 = 1'b0, gap1 = 1'b0, pat_on = 1'b0;
  logic [15:0] pat = 16'b1011_0010_1110_0101;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic logic [63:0] bdata(input int p, input int id, input int i);
    return (64'(p) << 56) | (64'(id) << 40) | 64'(i);
  endfunction

  task automatic push_frame(input int p, input int id, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = bdata(p, id, i);
      b.l = i == n - 1;
      b.k = b.l ? 8'h0F : 8'hFF;
      b.u = b.l && id[0];
      if (p == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic run(input int n);
    beat_t b0, b1, eb;
    logic v0, v1, mr, a0, a1, el;
    for (int c = 0; c < n; c++) begin
      @(negedge clk156);
      v0 = q0.size() > 0 && !gap0;
      v1 = q1.size() > 0 && !gap1;
      b0 = q0.size() > 0 ? q0[0] : '0;
      b1 = q1.size() > 0 ? q1[0] : '0;
      mr = pat_on ? pat[cyc % 16] : 1'b1;
      s0_axis_tvalid = v0;
      {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast, s0_axis_tuser} = b0;
      s1_axis_tvalid = v1;
      {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast, s1_axis_tuser} = b1;
      m_axis_tready = mr;
      #1;
      eb = own < 0 ? '0 : own == 0 ? b0 : b1;
      chk("grant", 64'(grant), own < 0 ? 64'd0 : own == 0 ? 64'd1 : 64'd2);
      chk("m_tvalid", 64'(m_axis_tvalid), own < 0 ? 64'd0 : 64'(own == 0 ? v0 : v1));
      chk("m_beat", {m_axis_tdata}, eb.d);
      chk("m_side", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'({eb.k, eb.l, eb.u}));
      chk("s0_tready", 64'(s0_axis_tready), 64'(own == 0 && mr));
      chk("s1_tready", 64'(s1_axis_tready), 64'(own == 1 && mr));
      chk("pkt_cnt0", 64'(pkt_cnt0), 64'(pk0));
      chk("pkt_cnt1", 64'(pkt_cnt1), 64'(pk1));
      chk("oversize", 64'(oversize), 64'(ov));
      if (m_axis_tvalid && m_axis_tready) begin
        obs.push_back(m_axis_tdata);
        if (t_first < 0) t_first = cyc;
      end
      a0 = own == 0 && v0 && mr;
      a1 = own == 1 && v1 && mr;
      el = eb.l;
      @(posedge clk156);
      if (!eth_rst_n) begin
        own = -1; last = 1; beat = 0; pk0 = 0; pk1 = 0; ov = 2'b00;
      end else if (own < 0) begin
        beat = 0;
        own = (v0 && v1) ? 1 - last : v0 ? 0 : v1 ? 1 : -1;
        if (own >= 0) glog.push_back(own);
      end else if (a0 || a1) begin
        beat = beat < MB ? beat + 1 : MB;
        if (beat == MB) ov[own] = 1'b1;
        if (el) begin
          if (own == 0) pk0++; else pk1++;
          last = own;
          own = -1;
        end
      end
      if (eth_rst_n && a0) void'(q0.pop_front());
      if (eth_rst_n && a1) void'(q1.pop_front());
      cyc++;
      #1;
    end
  endtask

  initial begin
    eth_rst_n = 1'b0;
    s0_axis_tvalid = 0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 0; s0_axis_tuser = 0;
    s1_axis_tvalid = 0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 0; s1_axis_tuser = 0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk156);
    #1;
    run(2);
    eth_rst_n = 1'b1;
    run(2);
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'd0);
    chk("reset_out", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep}) | m_axis_tdata, 64'd0);

    obs.delete(); t_first = -1; t_req = cyc;
    push_frame(0, 1, 4);
    run(6);
    chk("arb_latency", 64'(t_first - t_req), 64'd1);
    chk("frame4_beats", 64'(obs.size()), 64'd4);
    chk("frame4_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("frame4_gap_grant", 64'(grant), 64'd0);

    eth_rst_n = 1'b0;
    run(1);
    eth_rst_n = 1'b1;
    glog.delete();
    push_frame(0, 10, 3); push_frame(0, 11, 3);
    push_frame(1, 20, 2); push_frame(1, 21, 2);
    run(20);
    chk("rr_grants", 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(i % 2));
    chk("rr_cnt0", 64'(pkt_cnt0), 64'd2);
    chk("rr_cnt1", 64'(pkt_cnt1), 64'd2);

    obs.delete();
    push_frame(1, 30, 6);
    run(1);
    push_frame(0, 40, 2);
    pat_on = 1'b1;
    run(3);
    gap1 = 1'b1;
    run(2);
    gap1 = 1'b0;
    run(25);
    pat_on = 1'b0;
    chk("hold_beats", 64'(obs.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++)
      chk("hold_order", obs[i], i < 6 ? bdata(1, 30, i) : bdata(0, 40, i - 6));

    obs.delete();
    push_frame(0, 50, 7);
    run(9);
    chk("ovs_7beat", 64'(oversize), 64'd0);
    push_frame(0, 51, 10);
    run(8);
    chk("ovs_beat7", 64'(oversize), 64'd0);
    run(1);
    chk("ovs_beat8", 64'(oversize), 64'd1);
    run(3);
    chk("ovs_fwd", 64'(obs.size()), 64'd17);
    chk("ovs_sticky", 64'(oversize), 64'd1);
    chk("ovs_cnt0", 64'(pkt_cnt0), 64'd5);

    push_frame(1, 60, 6);
    run(3);
    eth_rst_n = 1'b0;
    run(1);
    chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_mid_grant", 64'(grant), 64'd0);
    chk("rst_mid_cnt1", 64'(pkt_cnt1), 64'd0);
    q1.delete();
    eth_rst_n = 1'b1;
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
